// File: rtl/riscie_mem_pkg.sv
// Shared definitions for the MEM pipeline stage: access-size encodings, FSM
// state type, and byte-enable / store-data replication helpers.
package riscie_mem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;  // 2'b11 decodes as word as well

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_e;

  // Byte-lane enables for an access of the given size at byte offset off
  // (8 lanes covers up to a 64-bit bus; callers truncate to their lane count).
  function automatic logic [7:0] be_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << off;
  endfunction

  // Replicate the LSB-aligned store datum across a 64-bit bus so every lane
  // holds the right byte whatever the offset; callers truncate to DATA_W.
  function automatic logic [63:0] wdata_rep(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_B:    return {8{d[7:0]}};
      SZ_H:    return {4{d[15:0]}};
      default: return {2{d}};
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: shifts the memory word down by the byte offset, masks
// to the access size and sign- or zero-extends.
//   rdata_i     memory read word
//   off_i       byte offset within the word
//   size_i      access size (SZ_B / SZ_H / word)
//   unsigned_i  zero-extend when set
//   data_c_o    aligned, extended result (combinational)
module mem_load_align
  import riscie_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  output logic [DATA_W-1:0] data_c_o
);

  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] mask;
  logic              sign;

  always_comb begin
    shifted = rdata_i >> {off_i, 3'b000};
    case (size_i)
      SZ_B: begin
        mask = DATA_W'(8'hFF);
        sign = shifted[7];
      end
      SZ_H: begin
        mask = DATA_W'(16'hFFFF);
        sign = shifted[15];
      end
      default: begin
        mask = DATA_W'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
    endcase
    data_c_o = shifted & mask;
    if (sign && !unsigned_i) begin
      data_c_o = data_c_o | ~mask;
    end
  end

endmodule

// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage between EX/MEM and MEM/WB. Issues loads/stores to a data
// memory over a req/ready handshake (wait states allowed), aligns and extends
// load data, backpressures EX while an access is outstanding, and pulses
// branch_taken back to IF.
// Optional build macro: MISALIGN_TRAP_EN -- misaligned half/word accesses
// issue no request and complete next cycle with wb_exc=1. Without it,
// misaligned offsets are rounded down to the access size and wb_exc is 0.
// Ports:
//   clk, rst_n                        clock, async active-low reset
//   ex_valid/ex_ready                 EX handshake
//   ex_addr, ex_wdata, ex_mem_read, ex_mem_write, ex_size, ex_unsigned,
//   ex_branch, ex_zero, ex_rd         operation fields from EX
//   dmem_req/we/addr/wdata/be         memory request (held until dmem_ready)
//   dmem_rdata, dmem_ready            memory response
//   wb_valid/data/addr/rd/exc         MEM/WB result (wb_valid is a pulse)
//   branch_taken                      one-cycle pulse to IF
module mem_stage_pipe
  import riscie_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned RD_W   = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_mem_read,
  input  logic                ex_mem_write,
  input  logic [1:0]          ex_size,
  input  logic                ex_unsigned,
  input  logic                ex_branch,
  input  logic                ex_zero,
  input  logic [RD_W-1:0]     ex_rd,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic [ADDR_W-1:0]   dmem_addr,
  output logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W/8-1:0] dmem_be,
  input  logic [DATA_W-1:0]   dmem_rdata,
  input  logic                dmem_ready,
  output logic                wb_valid,
  output logic [DATA_W-1:0]   wb_data,
  output logic [ADDR_W-1:0]   wb_addr,
  output logic [RD_W-1:0]     wb_rd,
  output logic                wb_exc,
  output logic                branch_taken
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  state_e              state_q, state_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]       be_q, be_d;
  logic [OFF_W-1:0]    off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
  logic                br_q, br_d;
  logic                accept;
  logic                is_mem;
  logic [OFF_W-1:0]    off_raw;
  logic [OFF_W-1:0]    off_eff;
  logic [DATA_W-1:0]   load_data_c;
`ifdef MISALIGN_TRAP_EN
  logic                exc_q, exc_d;
  logic                misaligned;
`endif

  assign accept  = ex_valid && (state_q == IDLE);
  assign is_mem  = ex_mem_read || ex_mem_write;
  assign off_raw = ex_addr[OFF_W-1:0];

`ifdef MISALIGN_TRAP_EN
  // Misaligned accesses trap, so the raw offset is used as-is.
  assign off_eff    = off_raw;
  assign misaligned = ((ex_size == SZ_H) && off_raw[0]) ||
                      ((ex_size != SZ_B) && (ex_size != SZ_H) && (off_raw[1:0] != 2'b00));
`else
  // Round the offset down to the access size.
  always_comb begin
    case (ex_size)
      SZ_B:    off_eff = off_raw;
      SZ_H:    off_eff = off_raw & ~OFF_W'(1);
      default: off_eff = off_raw & ~OFF_W'(3);
    endcase
  end
`endif

  mem_load_align #(
    .DATA_W (DATA_W),
    .OFF_W  (OFF_W)
  ) u_load_align (
    .rdata_i    (dmem_rdata),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_c_o   (load_data_c)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    off_d      = off_q;
    size_d     = size_q;
    uns_d      = uns_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_addr_d  = wb_addr_q;
    wb_rd_d    = wb_rd_q;
    br_d       = 1'b0;
`ifdef MISALIGN_TRAP_EN
    exc_d      = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          wb_addr_d = ex_addr;
          wb_rd_d   = ex_rd;
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            br_d       = ex_branch && ex_zero;
          end
`ifdef MISALIGN_TRAP_EN
          else if (misaligned) begin
            wb_valid_d = 1'b1;
            wb_data_d  = '0;
            exc_d      = 1'b1;
          end
`endif
          else begin
            // Read+write together is a store.
            state_d = ACCESS;
            req_d   = 1'b1;
            we_d    = ex_mem_write;
            addr_d  = {ex_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
            be_d    = ex_mem_write ? NB'(be_mask(ex_size, 3'(off_eff))) : '1;
            wdata_d = ex_mem_write ? DATA_W'(wdata_rep(ex_size, 32'(ex_wdata))) : '0;
            off_d   = off_eff;
            size_d  = ex_size;
            uns_d   = ex_unsigned;
          end
        end
      end
      ACCESS: begin
        if (dmem_ready) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_data_d  = we_q ? '0 : load_data_c;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      off_q      <= '0;
      size_q     <= '0;
      uns_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_addr_q  <= '0;
      wb_rd_q    <= '0;
      br_q       <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      exc_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      off_q      <= off_d;
      size_q     <= size_d;
      uns_q      <= uns_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_addr_q  <= wb_addr_d;
      wb_rd_q    <= wb_rd_d;
      br_q       <= br_d;
`ifdef MISALIGN_TRAP_EN
      exc_q      <= exc_d;
`endif
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_wdata   = wdata_q;
  assign dmem_be      = be_q;
  assign wb_valid     = wb_valid_q;
  assign wb_data      = wb_data_q;
  assign wb_addr      = wb_addr_q;
  assign wb_rd        = wb_rd_q;
  assign branch_taken = br_q;
`ifdef MISALIGN_TRAP_EN
  assign wb_exc       = exc_q;
`else
  assign wb_exc       = 1'b0;
`endif

endmodule
